// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions for the EX-stage divide sequencer.
// Holds the op/state encodings, iteration count and sign helper.
package rv32m_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam int DIV_ITERS = 32;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div_seq_div_step.sv
// One combinational radix-2 restoring division iteration.
// Shifts the dividend MSB into the partial remainder and trial-subtracts the divisor.
module div_step (
  input  logic [32:0] rem,
  input  logic        dvd_msb,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic        q_bit
);

  logic [33:0] shifted;
  logic [33:0] diff;

  // The remainder stays below the divisor, so bit 33 of the difference is a clean borrow.
  always_comb begin
    shifted  = {rem, dvd_msb};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[33];
    rem_next = q_bit ? diff[32:0] : shifted[32:0];
  end

endmodule

// File: rtl/ex_div_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer beside the EX-stage ALU.
// Stalls the front end while iterating and presents a registered result in DONE.
//
// state | meaning
// IDLE  | waiting for a divide in EX; accepts it the cycle i_start is seen
// CALC  | 32 restoring iterations, pipeline front stalled
// DONE  | o_result valid, instruction advances to EX/MEM
module ex_div_seq
  import rv32m_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [1:0]  i_div_op,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_valid,
  output logic [31:0] o_result
);

  div_state_e  state_q, state_d;
  div_op_e     op_q;
  logic        q_neg_q, r_neg_q;
  logic [31:0] dvd_q, dvs_q, result_q;
  logic [32:0] rem_q;
  logic [5:0]  cnt_q;

  div_op_e     op_in;
  logic        signed_in, special_in, start_ok, last_iter, step_q;
  logic [31:0] abs_a, abs_b, special_res, quot_final, fix_res;
  logic [32:0] step_rem;

  always_comb begin
    op_in       = div_op_e'(i_div_op);
    signed_in   = ~i_div_op[0];
    abs_a       = neg_if(signed_in & i_op_a[31], i_op_a);
    abs_b       = neg_if(signed_in & i_op_b[31], i_op_b);
    special_in  = 1'b0;
    special_res = 32'd0;
    if (i_op_b == 32'd0) begin
      special_in  = 1'b1;
      special_res = i_div_op[1] ? i_op_a : 32'hFFFF_FFFF;
    end else if (signed_in && i_op_a == DIV_OVF_DIVIDEND && i_op_b == 32'hFFFF_FFFF) begin
      special_in  = 1'b1;
      special_res = i_div_op[1] ? 32'd0 : DIV_OVF_DIVIDEND;
    end
  end

  assign start_ok  = (state_q == IDLE) && i_start && !i_flush;
  assign last_iter = (cnt_q == 6'(DIV_ITERS - 1));

  div_step u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[31]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // The dividend register collects quotient bits at its LSB as it shifts out.
  assign quot_final = {dvd_q[30:0], step_q};
  assign fix_res    = op_q[1] ? neg_if(r_neg_q, step_rem[31:0])
                              : neg_if(q_neg_q, quot_final);

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (i_start) state_d = special_in ? DONE : CALC;
        CALC:    if (last_iter) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_q     <= DIV;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 33'd0;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
    end else if (start_ok) begin
      op_q    <= op_in;
      q_neg_q <= signed_in & (i_op_a[31] ^ i_op_b[31]);
      r_neg_q <= signed_in & i_op_a[31];
      dvd_q   <= abs_a;
      dvs_q   <= abs_b;
      rem_q   <= 33'd0;
      cnt_q   <= 6'd0;
      if (special_in) result_q <= special_res;
    end else if (state_q == CALC && !i_flush) begin
      rem_q <= step_rem;
      dvd_q <= quot_final;
      cnt_q <= cnt_q + 6'd1;
      if (last_iter) result_q <= fix_res;
    end
  end

  assign o_stall  = !i_reset && !i_flush && ((state_q == IDLE && i_start) || state_q == CALC);
  assign o_valid  = (state_q == DONE) && !i_flush;
  assign o_result = result_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Scoreboard bench for ex_div_seq: random and directed divides against an arithmetic model.
module tb_ex_div_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] op_a, op_b;
  logic        stall, valid;
  logic [31:0] result;

  ex_div_seq dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_start  (start),
    .i_div_op (op),
    .i_op_a   (op_a),
    .i_op_b   (op_b),
    .i_flush  (flush),
    .o_stall  (stall),
    .o_valid  (valid),
    .o_result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int passed = 0;
  logic [31:0] last_exp = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Architectural result from plain 64-bit arithmetic, with the RISC-V corner cases.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    if (!o[0]) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result", result, e.res);
        check("valid_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int t, lat, stalls;
    bit got;
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    t     = cyc;
    lat   = is_special(o, a, b) ? 1 : 33;
    last_exp = ref_div(o, a, b);
    sbq.push_back('{res: last_exp, at: t + lat});
    stalls = 0;
    got    = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (valid) begin
        got = 1'b1;
        check("stall_at_valid", {31'd0, stall}, 32'd0);
      end else if (stall) begin
        stalls++;
      end
      if (i == 2) begin
        op_a = $urandom;
        op_b = $urandom;
      end
    end
    if (!got) check("valid_timeout", 32'd0, 32'd1);
    check("stall_cycles", 32'(stalls), 32'(lat));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int sel;

    rst = 1'b1; start = 1'b1; flush = 1'b0; op = 2'b01; op_a = 32'd100; op_b = 32'd7;
    #2;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_result", result, 32'd0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    run_op(2'b01, 32'd100, 32'd7);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE);
    idle(2);
    run_op(2'b00, 32'd5, 32'd0);
    run_op(2'b11, 32'd5, 32'd0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(1);

    for (int k = 0; k < 40; k++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3:    rb = 32'($urandom_range(1, 255));
        4:       rb = 32'd0 - 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    // Flush on the 10th CALC cycle kills the divide without touching o_result.
    start = 1'b1; op = 2'b01; op_a = 32'd1000; op_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_valid", {31'd0, valid}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_flush_stall", {31'd0, stall}, 32'd0);
    check("post_flush_result", result, last_exp);
    idle(3);
    run_op(2'b01, 32'd9, 32'd3);
    idle(2);

    // Reset in the middle of CALC clears everything at once.
    start = 1'b1; op = 2'b01; op_a = 32'h0000_FFFF; op_b = 32'd3;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_stall", {31'd0, stall}, 32'd0);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    check("midreset_result", result, 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(40);

    run_op(2'b01, 32'hFFFF_FFFF, 32'd1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1);
    idle(4);

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Multi-cycle RV32M divide sequencer that sits beside the EX-stage ALU. It accepts a DIV/DIVU/REM/REMU instruction held in EX, together with its already-forwarded rs1/rs2 operands, and runs a radix-2 restoring division over 32 iterations. While it works it stalls the front of the pipeline and holds the instruction in EX. It returns a registered 32-bit result for the EX/MEM register, resolves the architectural special cases in one cycle, and supports a flush.

## Interface
- Parameters: none. Width is fixed at 32.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  a valid divide-class instruction currently occupies EX.
- `i_div_op`  in  2  `div_op_e`: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `i_op_a`  in  32  forwarded rs1 (dividend); sampled only when a start is accepted.
- `i_op_b`  in  32  forwarded rs2 (divisor); sampled only when a start is accepted.
- `i_flush`  in  1  kill the instruction in EX (branch redirect or trap).
- `o_stall`  out  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- `o_valid`  out  1  `o_result` is valid this cycle; the instruction advances at the end of this cycle.
- `o_result`  out  32  quotient or remainder.

## Operation
- States (`div_state_e`):
  - IDLE → CALC on `i_start`, normal operands.
  - IDLE → DONE on `i_start`, special case.
  - CALC → DONE after 32 iterations.
  - DONE → IDLE unconditionally.
- Start acceptance (IDLE with `i_start`=1):
  - Latch the operation code, the sign flags, and the magnitudes |a| and |b|. Signed operations take the two's-complement absolute value; unsigned operations use the operands as-is.
  - Clear the 33-bit partial remainder.
  - Set the 6-bit iteration counter to 0.
- CALC, each cycle:
  - Shift {rem, dividend} left by 1.
  - Trial subtract: if rem − divisor ≥ 0, set the quotient bit and keep the difference; otherwise restore.
  - Increment the counter. Counter value 31 is the last iteration.
- Entering DONE: register `o_result` with sign fix-up applied:
  - Quotient is negated when the op is signed and the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases are detected at start and resolved directly into DONE:
  - b = 0: quotient is 0xFFFFFFFF; remainder is a (unmodified, any op).
  - DIV/REM with a = 0x80000000 and b = 0xFFFFFFFF: quotient is 0x80000000; remainder is 0.
- `o_stall` = !i_reset & !i_flush & ((IDLE & i_start) | CALC). It is combinational.
- `o_valid` = DONE & !i_flush.
- Flush in any state: next state is IDLE, no `o_valid`, `o_result` unchanged.
- Reset values: state IDLE; `o_result`, counter, remainder and quotient all 0; `o_valid` 0; `o_stall` 0 while `i_reset` is high.
- Reset asserted mid-CALC aborts immediately; no result is produced.

## Timing
- Normal path, start accepted at cycle T:
  - Cycles T..T+32: `o_stall`=1 (33 cycles).
  - Cycle T+33: DONE, `o_valid`=1, `o_stall`=0.
  - Occupancy in EX is 34 cycles.
- Special path: cycle T has `o_stall`=1; cycle T+1 has `o_valid`=1.
- `i_start` remains high during DONE for the same instruction. DONE → IDLE is unconditional, so the instruction is never restarted.
- Back-to-back divides: the next instruction enters EX at T+34 and is accepted in IDLE that cycle, with no dead cycle beyond IDLE.
- Operands are not re-sampled after T. Forwarding changes during CALC have no effect.
- `i_flush` and DONE in the same cycle: flush wins, `o_valid`=0.

## Structure
- Shared package `rv32m_pkg` holds:
  - `div_op_e`
  - `div_state_e` (IDLE, CALC, DONE)
  - `DIV_ITERS` = 32
  - constant `DIV_OVF_DIVIDEND` = 32'h8000_0000
- One natural sub-module: `div_step`. It is a combinational single restoring iteration:
  - in: rem[32:0], dividend MSB, divisor[31:0]
  - out: next rem, quotient bit
- Sign handling, the FSM and the counter stay in `ex_div_seq`.

## Test plan
- DIVU 100 / 7, start at T → `o_stall` high T..T+32; `o_valid` at T+33 with `o_result`=14. REMU with the same operands gives 2.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE → 0xFFFFFFFD.
- DIV 5 / 0 → 0xFFFFFFFF at T+1. REMU 5 / 0 → 5 at T+1. `o_stall` high only in cycle T.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1. REM with the same operands → 0.
- `i_flush` at the 10th CALC cycle → state IDLE next cycle, `o_stall`=0, no `o_valid`. A following DIVU 9 / 3 → 3 after the full 34-cycle latency.
- `i_reset` pulsed mid-CALC → all outputs 0 immediately. Two back-to-back DIVU 0xFFFFFFFF / 1 → both results 0xFFFFFFFF, valid at T+33 and T+67.
